// File: rtl/viola_pkg.sv
// Shared fetch-path types for the instruction queue: entry layout and RVC detection.
package viola_pkg;
  localparam int XLEN = 32;
  localparam logic [1:0] RVC_OPCODE_MASK = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic            is_rvc;
  } iq_entry_t;

  // Compressed words carry garbage in the upper half; clear it so decode sees a clean RVC.
  function automatic iq_entry_t make_entry(input logic [XLEN-1:0] instr,
                                           input logic [XLEN-1:0] pc);
    iq_entry_t e;
    e.instr  = instr;
    e.pc     = pc;
    e.is_rvc = ((instr[1:0] & RVC_OPCODE_MASK) != RVC_OPCODE_MASK);
    if (e.is_rvc) e.instr[XLEN-1:16] = '0;
    return e;
  endfunction
endpackage

// File: rtl/iq_storage.sv
// Entry array for the instruction queue: one write port, one asynchronous read port, no data reset.
module iq_storage
  import viola_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            i_clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_waddr,
  input  iq_entry_t       i_wdata,
  input  logic [AW-1:0]   i_raddr,
  output iq_entry_t       o_rdata
);
  iq_entry_t r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/instruction_queue.sv
// In-order fetch buffer between IC and decode: first-word-fall-through head, registered
// almost-full back-pressure, synchronous flush on redirect and a sticky overflow flag.
module instruction_queue
  import viola_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  input  logic [XLEN-1:0]        in_instr,
  input  logic [XLEN-1:0]        in_pc,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [XLEN-1:0]        out_instr,
  output logic [XLEN-1:0]        out_pc,
  output logic                   out_is_rvc,
  output logic                   iq_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH  = CW'(DEPTH);
  localparam logic [CW-1:0] C_MARGIN = CW'(FULL_MARGIN);

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_iq_full;
  logic          r_overflow;

  logic          w_nonempty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_set;
  logic [CW-1:0] w_count_next;
  logic          w_iq_full_next;
  iq_entry_t     w_wdata;
  iq_entry_t     w_head_entry;

  assign w_nonempty = (r_count != '0);
  assign w_full     = (r_count == C_DEPTH);
  assign w_pop      = w_nonempty && out_ready && !flush;
  // A pop in the same cycle frees a slot, so a full queue can still accept.
  assign w_push     = in_valid && !flush && (!w_full || w_pop);
  assign w_ovf_set  = in_valid && !flush && w_full && !w_pop;
  assign w_wdata    = make_entry(in_instr, in_pc);

  always_comb begin
    w_count_next = r_count;
    if (flush) begin
      w_count_next = '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   w_count_next = r_count + CW'(1);
        2'b01:   w_count_next = r_count - CW'(1);
        default: w_count_next = r_count;
      endcase
    end
  end

  assign w_iq_full_next = ((C_DEPTH - w_count_next) <= C_MARGIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_iq_full  <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        if (w_push) r_tail <= r_tail + AW'(1);
        if (w_pop)  r_head <= r_head + AW'(1);
      end
      r_count   <= w_count_next;
      r_iq_full <= w_iq_full_next;
      // Survives flush so a lost word is still visible after the redirect.
      if (w_ovf_set) r_overflow <= 1'b1;
    end
  end

  iq_storage #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_storage (
    .i_clk   (clk),
    .i_we    (w_push),
    .i_waddr (r_tail),
    .i_wdata (w_wdata),
    .i_raddr (r_head),
    .o_rdata (w_head_entry)
  );

  // Outputs are forced to zero when empty so reset and flush present a clean interface.
  assign out_valid    = w_nonempty;
  assign out_instr    = w_nonempty ? w_head_entry.instr  : '0;
  assign out_pc       = w_nonempty ? w_head_entry.pc     : '0;
  assign out_is_rvc   = w_nonempty ? w_head_entry.is_rvc : 1'b0;
  assign iq_full      = r_iq_full;
  assign count        = r_count;
  assign overflow_err = r_overflow;
endmodule

// File: tb/tb_instruction_queue.sv
// Directed self-checking bench for instruction_queue (DEPTH=16, FULL_MARGIN=2).
module tb_instruction_queue;
  import viola_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_rvc;
  logic        iq_full;
  logic [4:0]  count;
  logic        overflow_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  instruction_queue #(.DEPTH(16), .FULL_MARGIN(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .in_pc        (in_pc),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .out_is_rvc   (out_is_rvc),
    .iq_full      (iq_full),
    .count        (count),
    .overflow_err (overflow_err)
  );

  task automatic idle();
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic [31:0] instr, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc    = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (count !== 5'd0) $display("FAIL rst_count: got %0d want 0", count); else n_pass++;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else n_pass++;
    n_total++; if (iq_full !== 1'b0 || overflow_err !== 1'b0)
      $display("FAIL rst_flags: got full=%b ovf=%b want 0/0", iq_full, overflow_err); else n_pass++;
    for (int i = 0; i < 5; i++) push(32'h0000_0013, 32'(i * 4));
    n_total++; if (count !== 5'd5) $display("FAIL rst_pre_count: got %0d want 5", count); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if (out_valid !== 1'b0 || out_instr !== 32'h0 || out_pc !== 32'h0 || out_is_rvc !== 1'b0)
      $display("FAIL rst_async_out: got v=%b instr=%h pc=%h rvc=%b want all 0",
               out_valid, out_instr, out_pc, out_is_rvc); else n_pass++;
    n_total++; if (count !== 5'd0 || iq_full !== 1'b0)
      $display("FAIL rst_async_cnt: got count=%0d full=%b want 0/0", count, iq_full); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_total++; if (count !== 5'd0 || out_valid !== 1'b0)
      $display("FAIL rst_release: got count=%0d valid=%b want 0/0", count, out_valid); else n_pass++;
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 13; i++) push(32'h0000_0013, 32'(i * 4));
    n_total++; if (iq_full !== 1'b0 || count !== 5'd13)
      $display("FAIL fill_13: got full=%b count=%0d want 0/13", iq_full, count); else n_pass++;
    push(32'h0000_0013, 32'd52);
    n_total++; if (iq_full !== 1'b1 || count !== 5'd14)
      $display("FAIL fill_14: got full=%b count=%0d want 1/14", iq_full, count); else n_pass++;
    push(32'h0000_0013, 32'd56);
    push(32'h0000_0013, 32'd60);
    n_total++; if (count !== 5'd16 || overflow_err !== 1'b0)
      $display("FAIL fill_16: got count=%0d ovf=%b want 16/0", count, overflow_err); else n_pass++;
    push(32'h0000_0013, 32'd64);
    n_total++; if (count !== 5'd16 || overflow_err !== 1'b1)
      $display("FAIL fill_drop: got count=%0d ovf=%b want 16/1", count, overflow_err); else n_pass++;
    n_total++; if (out_pc !== 32'h0) $display("FAIL fill_head: got pc=%h want 0", out_pc); else n_pass++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    n_total++; if (count !== 5'd0 || iq_full !== 1'b0 || overflow_err !== 1'b1)
      $display("FAIL fill_flush_sticky: got count=%0d full=%b ovf=%b want 0/0/1",
               count, iq_full, overflow_err); else n_pass++;
  endtask

  task automatic test_full_simul();
    do_reset();
    for (int i = 0; i < 16; i++) push(32'h0000_0013, 32'(i * 4));
    in_valid  = 1'b1;
    in_instr  = 32'h0000_0013;
    in_pc     = 32'h40;
    out_ready = 1'b1;
    @(negedge clk);
    idle();
    n_total++; if (count !== 5'd16 || overflow_err !== 1'b0)
      $display("FAIL simul_full: got count=%0d ovf=%b want 16/0", count, overflow_err); else n_pass++;
    n_total++; if (out_pc !== 32'h4 || iq_full !== 1'b1)
      $display("FAIL simul_head: got pc=%h full=%b want 4/1", out_pc, iq_full); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 6; i++) push(32'h0000_0013, 32'(i * 4));
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_pc     = 32'h18;
    out_ready = 1'b1;
    @(negedge clk);
    idle();
    n_total++; if (count !== 5'd0 || out_valid !== 1'b0 || iq_full !== 1'b0)
      $display("FAIL flush_clear: got count=%0d valid=%b full=%b want 0/0/0",
               count, out_valid, iq_full); else n_pass++;
    push(32'h0000_0013, 32'h200);
    n_total++; if (count !== 5'd1 || out_pc !== 32'h200)
      $display("FAIL flush_restart: got count=%0d pc=%h want 1/200", count, out_pc); else n_pass++;
  endtask

  task automatic test_rvc();
    do_reset();
    push(32'hABCD_4501, 32'h100);
    n_total++; if (out_valid !== 1'b1 || out_is_rvc !== 1'b1 || out_instr !== 32'h0000_4501 || out_pc !== 32'h100)
      $display("FAIL rvc_16: got v=%b rvc=%b instr=%h pc=%h want 1/1/00004501/100",
               out_valid, out_is_rvc, out_instr, out_pc); else n_pass++;
    push(32'h0000_0013, 32'h102);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_total++; if (out_is_rvc !== 1'b0 || out_instr !== 32'h0000_0013 || out_pc !== 32'h102)
      $display("FAIL rvc_32: got rvc=%b instr=%h pc=%h want 0/00000013/102",
               out_is_rvc, out_instr, out_pc); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int sent = 0;
    int rcv  = 0;
    int bad  = 0;
    logic pop_now;
    do_reset();
    for (int cyc = 0; cyc < 2000 && rcv < 40; cyc++) begin
      in_valid  = (sent < 40) && !iq_full;
      in_instr  = 32'h0000_0013;
      in_pc     = 32'(sent * 4);
      out_ready = 1'($urandom_range(0, 1));
      pop_now   = out_valid && out_ready;
      if (pop_now) begin
        n_total++;
        if (out_pc !== 32'(rcv * 4)) begin
          $display("FAIL order_pc: got %h want %h", out_pc, 32'(rcv * 4));
          bad++;
        end else n_pass++;
        rcv++;
      end
      if (in_valid && (count < 5'd16 || pop_now)) sent++;
      @(negedge clk);
    end
    idle();
    n_total++; if (rcv != 40) $display("FAIL order_count: got %0d words want 40", rcv); else n_pass++;
    n_total++; if (count !== 5'd0 || overflow_err !== 1'b0)
      $display("FAIL order_end: got count=%0d ovf=%b want 0/0", count, overflow_err); else n_pass++;
    if (bad != 0) $display("order errors: %0d", bad);
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_simul();
    test_flush();
    test_rvc();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
